sat_accum: RTL and testbench
============================

// Module: sat_accum
// PURPOSE
// - Windowed signed accumulator on a valid/ready stream; sits directly downstream of the
//   negation stage and consumes its signed DIN-bit output.
// - Sums CNT consecutive accepted samples, then presents one DOUT-bit signed sum on dout.
// - Optionally clamps the running sum instead of letting it wrap.
// PARAMETERS
// - DIN   16  input sample width, two's complement
// - DOUT  24  output/accumulator width, two's complement; must satisfy DOUT >= DIN
// - CNT    8  samples per window; must satisfy CNT >= 1
// PORTS
// - clk         in   1     single clock, all state updates on rising edge
// - rst         in   1     synchronous, active-high reset
// - din_ready   out  1     sample accepted when din_valid & din_ready
// - din_valid   in   1     upstream sample valid
// - din_data    in   DIN   signed sample
// - dout_ready  in   1     downstream accepts the sum
// - dout_valid  out  1     sum valid; held until accepted
// - dout_data   out  DOUT  signed window sum
// BEHAVIOUR
// - Reset: acc=0, cnt=0, state=ACC, dout_valid=0, dout_data=0. Reset has priority and
//   discards any partial window and any pending unaccepted sum.
// - State ACC:
//   - din_ready=1, dout_valid=0.
//   - On accept: acc <= f(acc + sext(din_data)), cnt <= cnt+1.
//   - On the accept with cnt==CNT-1: dout_data <= f(acc + sext(din_data)), acc <= 0,
//     cnt <= 0, state <= OUT.
// - State OUT:
//   - dout_valid=1; dout_data stable until the output is accepted.
//   - din_ready = dout_ready (combinational), so the first sample of the next window is
//     accepted in the same cycle the sum is taken.
//   - On dout accept: with a simultaneous din accept, that sample seeds the new window:
//     acc <= f(sext(din)), cnt <= 1. If CNT==1, dout_data <= f(sext(din)) and state stays
//     OUT. Otherwise state <= ACC.
//   - dout_ready=0: no input accepted, no state change.
// - Latency: dout_valid asserts the cycle after the CNT-th sample is accepted.
// - Throughput: one sample per clock when both sides are always ready.
// - f(): sign-extend all operands to DOUT+1 bits, add, then reduce to DOUT bits; see
//   CONFIGURATION.
// - Clamping is applied per step to the running sum, so the saturated result depends on
//   sample order.
// - din_valid gaps: acc and cnt hold; no timeout.
// - No combinational path from din_valid to dout_valid. The only comb path is
//   dout_ready -> din_ready in OUT.
// CONFIGURATION
// - SAT_ACCUM_SAT_EN defined:
//   - f() clamps to [-2^(DOUT-1), 2^(DOUT-1)-1].
//   - Overflow is detected as both operands having the same sign and the result sign
//     differing.
// - SAT_ACCUM_SAT_EN undefined:
//   - f() keeps the low DOUT bits (modulo 2^DOUT wrap).
//   - No clamp logic is instantiated.
// TESTING (DIN=8, DOUT=9, CNT=4 unless noted)
// - Basic: samples 1,2,3,4 back-to-back, dout_ready=1 -> dout_data=10, valid for one
//   cycle, one clock after sample 4.
// - Overflow: 127 x4 -> SAT_EN: 255; no SAT_EN: -4.
// - Underflow: -128 x4 -> SAT_EN: -256; no SAT_EN: 0.
// - Backpressure: window 5,5,5,5 with dout_ready=0 for 5 cycles -> dout_valid=1 and
//   dout_data=20 stable, din_ready=0 throughout. Then raise dout_ready with din_valid=1,
//   din=7 -> both accepted in one cycle; next 3 samples of 1 -> 10.
// - Reset mid-window: accept 9,9; assert rst 1 cycle; then 1,1,1,1 -> dout_data=4.
// - CNT=1, no SAT_EN: stream -3,100,-128 with random dout_ready/din_valid gaps ->
//   outputs -3,100,-128, in order, none lost or duplicated.

Source files
------------

// File: rtl/sat_accum_if.sv
// -----------------------------------------------------------------------------
// sat_accum_if
// Single-direction valid/ready stream bundle used on both sides of sat_accum.
//
// Parameters
//   W      payload width in bits
//
// Signals
//   valid  producer -> consumer   payload is valid this cycle
//   ready  consumer -> producer   consumer takes the payload when valid & ready
//   data   producer -> consumer   payload, W bits
//
// Modports
//   master  the producing side (drives valid/data, observes ready)
//   slave   the consuming side (observes valid/data, drives ready)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface sat_accum_if #(
  parameter int W = 16
) ();

  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface : sat_accum_if

// File: rtl/sat_accum.sv
// -----------------------------------------------------------------------------
// sat_accum
// Windowed signed accumulator on a valid/ready stream. Sums CNT consecutive
// accepted two's-complement samples and presents one DOUT-bit signed sum per
// window on the output stream. The sum is held until the downstream takes it.
//
// Optional feature (compile-time macro SAT_ACCUM_SAT_EN):
//   defined   : each accumulation step clamps to [-2^(DOUT-1), 2^(DOUT-1)-1]
//   undefined : each accumulation step wraps modulo 2^DOUT (no clamp logic)
//
// Parameters
//   DIN    input sample width (two's complement)
//   DOUT   accumulator / output width (two's complement), DOUT >= DIN
//   CNT    samples per window, CNT >= 1
//
// Ports
//   clk    in      single clock, rising edge
//   rst    in      synchronous, active-high reset
//   din    slave   input stream  (valid/data in, ready out), DIN-bit samples
//   dout   master  output stream (valid/data out, ready in), DOUT-bit sums
//
// Timing
//   - dout.valid is registered (state only); no path from din.valid to it.
//   - din.ready is 1 while accumulating, and equals dout.ready while a sum is
//     pending, so the first sample of the next window can enter in the same
//     cycle the previous sum is taken. This is the only combinational path.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sat_accum #(
  parameter int DIN  = 16,
  parameter int DOUT = 24,
  parameter int CNT  = 8
) (
  input  logic          clk,
  input  logic          rst,
  sat_accum_if.slave    din,
  sat_accum_if.master   dout
);

  // Counter is wide enough to hold CNT itself, which keeps it at least one bit
  // wide even when CNT == 1.
  localparam int CW = $clog2(CNT + 1);
  localparam logic [CW-1:0] LAST = CW'(CNT - 1);

  typedef enum logic {
    ST_ACC,   // collecting samples of the current window
    ST_OUT    // window sum presented, waiting for downstream
  } state_t;

  typedef logic signed [DOUT-1:0] acc_t;

  // ---------------------------------------------------------------------------
  // One accumulation step: a + b reduced to DOUT bits.
  // The DOUT-bit sum equals the low bits of the exact (DOUT+1)-bit sum, so the
  // wrapping build needs nothing more. The clamping build detects overflow as
  // equal operand signs with a differing result sign, and then picks the
  // extreme matching the operands' sign.
  // ---------------------------------------------------------------------------
  function automatic acc_t f_add(input acc_t a, input acc_t b);
    acc_t s;
    s = a + b;
`ifdef SAT_ACCUM_SAT_EN
    if ((a[DOUT-1] == b[DOUT-1]) && (s[DOUT-1] != a[DOUT-1])) begin
      s = a[DOUT-1] ? {1'b1, {(DOUT-1){1'b0}}}    // most negative
                    : {1'b0, {(DOUT-1){1'b1}}};   // most positive
    end
`endif
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t          state, state_nx;
  acc_t            acc,   acc_nx;
  logic [CW-1:0]   cnt,   cnt_nx;
  acc_t            data_q, data_nx;

  // ---------------------------------------------------------------------------
  // Input side
  // ---------------------------------------------------------------------------
  logic signed [DIN-1:0] din_s;
  acc_t                  din_ext;
  logic                  din_rdy;
  logic                  din_fire;

  assign din_s    = din.data;
  assign din_ext  = DOUT'(din_s);                 // sign extension to DOUT
  assign din_rdy  = (state == ST_ACC) || dout.ready;
  assign din_fire = din.valid && din_rdy;

  assign din.ready  = din_rdy;
  assign dout.valid = (state == ST_OUT);
  assign dout.data  = data_q;

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // A sample accepted while the previous sum is being taken behaves exactly
  // like the first sample of a fresh window (empty accumulator, count 0). With
  // CNT == 1 that same sample also completes its window, so the machine stays
  // in ST_OUT with the new sum and the accumulator cleared again.
  // ---------------------------------------------------------------------------
  acc_t          base_acc;
  logic [CW-1:0] base_cnt;
  logic          take;
  acc_t          step_sum;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // through this block leaves one unassigned and no latch is inferred.
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    data_nx  = data_q;
    base_acc = acc;
    base_cnt = cnt;
    take     = 1'b0;

    unique case (state)
      ST_ACC: begin
        take = din_fire;
      end
      ST_OUT: begin
        // Without dout.ready nothing moves: din_rdy is low, the sum is held.
        if (dout.ready) begin
          state_nx = ST_ACC;
          base_acc = '0;
          base_cnt = '0;
          take     = din_fire;
        end
      end
      default: begin
        state_nx = ST_ACC;
      end
    endcase

    step_sum = f_add(base_acc, din_ext);

    if (take) begin
      if (base_cnt == LAST) begin
        data_nx  = step_sum;
        acc_nx   = '0;
        cnt_nx   = '0;
        state_nx = ST_OUT;
      end else begin
        acc_nx = step_sum;
        cnt_nx = base_cnt + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State register. Reset discards any partial window and any pending sum.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (rst) begin
      state  <= ST_ACC;
      acc    <= '0;
      cnt    <= '0;
      data_q <= '0;
    end else begin
      state  <= state_nx;
      acc    <= acc_nx;
      cnt    <= cnt_nx;
      data_q <= data_nx;
    end
  end

endmodule : sat_accum

// File: tb/tb_sat_accum.sv
// -----------------------------------------------------------------------------
// tb_sat_accum
// Self-checking bench for sat_accum with DIN=8, DOUT=9. Two instances:
//   u_dut4  CNT=4  table vectors, reset mid-window, randomized stream
//   u_dut1  CNT=1  ordered pass-through of -3,100,-128 under random gaps
// The reference model works on plain integers: it keeps a running window
// total, reduces each step by clamping or modulo wrap (matching the build's
// SAT_ACCUM_SAT_EN setting), and a queue of produced sums awaiting pickup.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sat_accum;

  localparam int DIN  = 8;
  localparam int DOUT = 9;
  localparam int CNT  = 4;

`ifdef SAT_ACCUM_SAT_EN
  localparam int OVF_SUM = 255;
  localparam int UNF_SUM = -256;
`else
  localparam int OVF_SUM = -4;
  localparam int UNF_SUM = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sat_accum_if #(.W(DIN))  din4  ();
  sat_accum_if #(.W(DOUT)) dout4 ();
  sat_accum_if #(.W(DIN))  din1  ();
  sat_accum_if #(.W(DOUT)) dout1 ();

  sat_accum #(.DIN(DIN), .DOUT(DOUT), .CNT(CNT)) u_dut4 (
    .clk  (clk),
    .rst  (rst),
    .din  (din4),
    .dout (dout4)
  );

  sat_accum #(.DIN(DIN), .DOUT(DOUT), .CNT(1)) u_dut1 (
    .clk  (clk),
    .rst  (rst),
    .din  (din1),
    .dout (dout1)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model for the CNT=4 instance
  // ---------------------------------------------------------------------------
  int m_run = 0;        // running window total (already reduced per step)
  int m_n   = 0;        // samples in the current window
  int m_out[$];         // sums produced and not yet taken downstream

  function automatic int reduce(input int s);
    int r;
`ifdef SAT_ACCUM_SAT_EN
    r = (s > 255) ? 255 : (s < -256) ? -256 : s;
`else
    r = ((s % 512) + 512) % 512;
    if (r >= 256) r = r - 512;
`endif
    return r;
  endfunction

  function automatic int sx8(input int d);
    logic signed [7:0] b;
    b = d[7:0];
    return int'(b);
  endfunction

  function automatic int sx9(input logic [8:0] d);
    logic signed [8:0] b;
    b = d;
    return int'(b);
  endfunction

  task automatic model_reset();
    m_run = 0;
    m_n   = 0;
    m_out.delete();
  endtask

  // Drive the CNT=4 instance inputs and let combinational outputs settle.
  task automatic apply4(input bit v, input int d, input bit r);
    din4.valid = v;
    din4.data  = d[7:0];
    dout4.ready = r;
    #1;
  endtask

  // Compare observed handshake/data with the model, then advance the model
  // by what this cycle transfers.
  task automatic model_check4();
    bit exp_vld;
    bit exp_rdy;
    exp_vld = (m_out.size() != 0);
    exp_rdy = !exp_vld || dout4.ready;
    check("din_ready",  int'(din4.ready),  int'(exp_rdy));
    check("dout_valid", int'(dout4.valid), int'(exp_vld));
    if (exp_vld) begin
      check("dout_data", sx9(dout4.data), m_out[0]);
      if (dout4.ready) void'(m_out.pop_front());
    end
    if (din4.valid && exp_rdy) begin
      m_run = reduce(m_run + sx8(int'(din4.data)));
      m_n++;
      if (m_n == CNT) begin
        m_out.push_back(m_run);
        m_run = 0;
        m_n   = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step4(input bit v, input int d, input bit r);
    apply4(v, d, r);
    model_check4();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply4(1'b0, 0, 1'b0);
    din1.valid  = 1'b0;
    din1.data   = '0;
    dout1.ready = 1'b0;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit v;
    int d;
    bit r;
    bit e_rdy;
    bit e_vld;
    int e_data;   // checked only when e_vld
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit v, input int d, input bit r,
                     input bit e_rdy, input bit e_vld, input int e_data);
    vec_t t;
    t.v = v; t.d = d; t.r = r;
    t.e_rdy = e_rdy; t.e_vld = e_vld; t.e_data = e_data;
    tbl.push_back(t);
  endtask

  // CNT=1 instance bookkeeping
  int seq1[3] = '{-3, 100, -128};

  initial begin
    int sent;
    int got;
    int cyc;
    bit pend;
    int pend_val;

    din4.valid = 1'b0; din4.data = '0; dout4.ready = 1'b0;
    din1.valid = 1'b0; din1.data = '0; dout1.ready = 1'b0;
    #2;
    do_reset();

    // Reset state
    #1;
    check("rst_din_ready",  int'(din4.ready),  1);
    check("rst_dout_valid", int'(dout4.valid), 0);
    check("rst_dout_data",  sx9(dout4.data),   0);

    // Basic window 1,2,3,4, sum visible one clock after sample 4, one cycle only
    add(1, 1, 1, 1, 0, 0);
    add(1, 2, 1, 1, 0, 0);
    add(1, 3, 1, 1, 0, 0);
    add(1, 4, 1, 1, 0, 0);
    add(0, 0, 1, 1, 1, 10);
    add(0, 0, 1, 1, 0, 0);
    // Backpressure: 5 x4, held for 5 cycles with din_ready low
    for (int i = 0; i < 4; i++) add(1, 5, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) add(1, 99, 0, 0, 1, 20);
    // Sum taken and 7 accepted in the same cycle, then 1,1,1 -> 10
    add(1, 7, 1, 1, 1, 20);
    for (int i = 0; i < 3; i++) add(1, 1, 1, 1, 0, 0);
    add(0, 0, 1, 1, 1, 10);
    add(0, 0, 1, 1, 0, 0);
    // Overflow and underflow
    for (int i = 0; i < 4; i++) add(1, 127, 1, 1, 0, 0);
    add(0, 0, 1, 1, 1, OVF_SUM);
    add(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(1, -128, 1, 1, 0, 0);
    add(0, 0, 1, 1, 1, UNF_SUM);
    add(0, 0, 1, 1, 0, 0);

    foreach (tbl[i]) begin
      apply4(tbl[i].v, tbl[i].d, tbl[i].r);
      check($sformatf("tbl%0d_ready", i), int'(din4.ready),  int'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_valid", i), int'(dout4.valid), int'(tbl[i].e_vld));
      if (tbl[i].e_vld)
        check($sformatf("tbl%0d_data", i), sx9(dout4.data), tbl[i].e_data);
      model_check4();
      tick();
    end

    // Reset mid-window: 9,9 discarded, then 1,1,1,1 -> 4
    step4(1, 9, 1);
    step4(1, 9, 1);
    do_reset();
    for (int i = 0; i < 4; i++) step4(1, 1, 1);
    apply4(0, 0, 1);
    check("rstmid_valid", int'(dout4.valid), 1);
    check("rstmid_data",  sx9(dout4.data),   4);
    model_check4();
    tick();

    // Randomized stream against the model; extremes mixed in for the clamp
    for (int i = 0; i < 600; i++) begin
      int d;
      case ($urandom_range(0, 3))
        0:       d = 127;
        1:       d = -128;
        default: d = sx8(int'($urandom_range(0, 255)));
      endcase
      step4($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 3; i++) step4(0, 0, 1);
    check("rand_drained", m_out.size(), 0);

    // CNT=1: every accepted sample is its own window and comes out in order
    do_reset();
    sent = 0; got = 0; cyc = 0; pend = 0; pend_val = 0;
    while (got < 3 && cyc < 300) begin
      bit v;
      bit r;
      bit exp_rdy;
      v = (sent < 3) && ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 2) != 0;
      din1.valid  = v;
      din1.data   = (sent < 3) ? seq1[sent][7:0] : 8'h00;
      dout1.ready = r;
      #1;
      exp_rdy = !pend || r;
      check("cnt1_ready", int'(din1.ready),  int'(exp_rdy));
      check("cnt1_valid", int'(dout1.valid), int'(pend));
      if (pend && r) begin
        check($sformatf("cnt1_out%0d", got), sx9(dout1.data), seq1[got]);
        got++;
        pend = 0;
      end
      if (v && exp_rdy) begin
        pend     = 1;
        pend_val = seq1[sent];
        sent++;
      end
      if (pend) check("cnt1_hold_val", pend_val, seq1[sent - 1]);
      tick();
      cyc++;
    end
    check("cnt1_count", got, 3);
    din1.valid = 1'b0;
    dout1.ready = 1'b1;
    #1;
    check("cnt1_no_extra", int'(dout1.valid), 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_sat_accum
